// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver: active-high a..g patterns and pin layout.
package seven_seg_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned PIN_W   = 8;
  localparam int unsigned NIB_W   = 4;

  localparam int unsigned SEG_A   = 0;
  localparam int unsigned SEG_B   = 1;
  localparam int unsigned SEG_C   = 2;
  localparam int unsigned SEG_D   = 3;
  localparam int unsigned SEG_E   = 4;
  localparam int unsigned SEG_F   = 5;
  localparam int unsigned SEG_G   = 6;
  localparam int unsigned SEG_DP  = 7;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;
  localparam logic [SEG_W-1:0] SEG_0   = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1   = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2   = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3   = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4   = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5   = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6   = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7   = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8   = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9   = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_HA  = 7'h77;
  localparam logic [SEG_W-1:0] SEG_HB  = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_HC  = 7'h39;
  localparam logic [SEG_W-1:0] SEG_HD  = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_HE  = 7'h79;
  localparam logic [SEG_W-1:0] SEG_HF  = 7'h71;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-high a..g segment pattern.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_OFF;
    case (nibble)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = SEG_HA;
      4'hB: seg_c = SEG_HB;
      4'hC: seg_c = SEG_HC;
      4'hD: seg_c = SEG_HD;
      4'hE: seg_c = SEG_HE;
      4'hF: seg_c = SEG_HF;
      default: seg_c = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed N-digit seven-segment scanner with frame-synchronous valid/ready load,
// leading-zero blanking, per-digit blink and decimal points. Requires DIV_BITS>=1, BLINK_BITS>=1.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int unsigned N_DIGITS   = 4,
  parameter int unsigned DIV_BITS   = 16,
  parameter int unsigned BLINK_BITS = 6,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*N_DIGITS-1:0]     data_in,
  input  logic [N_DIGITS-1:0]       dp_in,
  input  logic [N_DIGITS-1:0]       blink_mask,
  input  logic                      blank_lz,
  input  logic                      load_valid,
  output logic                      load_ready,
  output logic [N_DIGITS-1:0]       anode,
  output logic [PIN_W-1:0]          sevenSeg,
  output logic                      frame_tick
);

  localparam int unsigned DATA_W = NIB_W * N_DIGITS;
  localparam int unsigned IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] ANODE_OFF = {N_DIGITS{ACTIVE_LOW}};
  localparam logic [PIN_W-1:0]    PINS_OFF  = {PIN_W{ACTIVE_LOW}};

  logic [DIV_BITS-1:0]   pre_q;
  logic [DIV_BITS-1:0]   pre_nxt_c;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      idx_nxt_c;
  logic [BLINK_BITS-1:0] blink_q;

  logic [DATA_W-1:0]     disp_data_q;
  logic [N_DIGITS-1:0]   disp_dp_q;
  logic [N_DIGITS-1:0]   disp_blink_q;
  logic                  disp_lz_q;
  logic [DATA_W-1:0]     pend_data_q;
  logic [N_DIGITS-1:0]   pend_dp_q;
  logic [N_DIGITS-1:0]   pend_blink_q;
  logic                  pend_lz_q;
  logic                  pend_full_q;

  logic                  term_c;
  logic                  bnd_c;
  logic                  tick_nxt_c;
  logic                  hs_c;
  logic                  pend_full_nxt_c;

  logic [NIB_W-1:0]      nib_c;
  logic [SEG_W-1:0]      seg_c;
  logic [N_DIGITS-1:0]   lz_dark_c;
  logic [N_DIGITS-1:0]   sel_c;
  logic                  zero_run_c;
  logic                  dark_c;
  logic [PIN_W-1:0]      pins_on_c;

  // Scan timing; frame_tick is registered one cycle ahead so it lines up with the boundary cycle
  always_comb begin
    term_c    = &pre_q;
    bnd_c     = term_c && (idx_q == LAST_IDX);
    pre_nxt_c = pre_q + DIV_BITS'(1);
    idx_nxt_c = idx_q;
    if (term_c) begin
      idx_nxt_c = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    end
    tick_nxt_c = (&pre_nxt_c) && (idx_nxt_c == LAST_IDX);
  end

  // Load handshake: pending reg fills any time, drains into display only on a frame boundary
  always_comb begin
    hs_c            = load_valid && load_ready;
    pend_full_nxt_c = pend_full_q;
    if (bnd_c && pend_full_q) begin
      pend_full_nxt_c = 1'b0;
    end else if (hs_c) begin
      pend_full_nxt_c = 1'b1;
    end
  end

  // Leading-zero run from the most significant digit down; digit 0 is never blanked
  always_comb begin
    lz_dark_c  = '0;
    zero_run_c = disp_lz_q;
    for (int i = int'(N_DIGITS) - 1; i > 0; i--) begin
      zero_run_c   = zero_run_c && (disp_data_q[NIB_W*i +: NIB_W] == 4'h0);
      lz_dark_c[i] = zero_run_c;
    end
  end

  always_comb begin
    nib_c     = disp_data_q[{idx_q, 2'b00} +: NIB_W];
    sel_c     = N_DIGITS'(1) << idx_q;
    pins_on_c = {disp_dp_q[idx_q], seg_c};
    // First cycle of each dwell is dark to suppress ghosting across the anode switch
    dark_c    = (pre_q == '0) || lz_dark_c[idx_q] ||
                (blink_q[BLINK_BITS-1] && disp_blink_q[idx_q]);
  end

  hex_to_seg u_dec (
    .nibble (nib_c),
    .seg_c  (seg_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q        <= '0;
      idx_q        <= '0;
      blink_q      <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blink_q <= '0;
      disp_lz_q    <= 1'b0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blink_q <= '0;
      pend_lz_q    <= 1'b0;
      pend_full_q  <= 1'b0;
      load_ready   <= 1'b1;
      frame_tick   <= 1'b0;
      anode        <= ANODE_OFF;
      sevenSeg     <= PINS_OFF;
    end else begin
      pre_q       <= pre_nxt_c;
      idx_q       <= idx_nxt_c;
      frame_tick  <= tick_nxt_c;
      pend_full_q <= pend_full_nxt_c;
      load_ready  <= !pend_full_nxt_c;
      if (bnd_c) begin
        blink_q <= blink_q + BLINK_BITS'(1);
      end
      if (bnd_c && pend_full_q) begin
        disp_data_q  <= pend_data_q;
        disp_dp_q    <= pend_dp_q;
        disp_blink_q <= pend_blink_q;
        disp_lz_q    <= pend_lz_q;
      end else if (hs_c) begin
        pend_data_q  <= data_in;
        pend_dp_q    <= dp_in;
        pend_blink_q <= blink_mask;
        pend_lz_q    <= blank_lz;
      end
      // XOR with the off level maps active-high selections onto the pin polarity
      if (dark_c) begin
        anode    <= ANODE_OFF;
        sevenSeg <= PINS_OFF;
      end else begin
        anode    <= sel_c ^ ANODE_OFF;
        sevenSeg <= pins_on_c ^ PINS_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench: accepted loads queue the display state they will produce; a monitor checks each scanned frame.
module tb_seven_seg_scan_driver;

  localparam int N     = 4;
  localparam int DIV   = 2;
  localparam int BLINK = 1;
  localparam int FRAME = N * (1 << DIV);
  localparam int LIT   = (1 << DIV) - 1;

  typedef struct {
    int          start;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  mask;
    logic        lz;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink_mask = '0;
  logic        blank_lz = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [3:0]  anode;
  logic [7:0]  sevenSeg;
  logic        frame_tick;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc;
  int   last_b  = -1;
  bit   done    = 1'b0;
  rec_t q[$];
  rec_t cur;
  int          lit_cnt [4];
  logic [7:0]  seg_seen [4];
  bit          seg_bad [4];
  logic [7:0]  tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seven_seg_scan_driver #(
    .N_DIGITS   (N),
    .DIV_BITS   (DIV),
    .BLINK_BITS (BLINK),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blink_mask (blink_mask),
    .blank_lz   (blank_lz),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .anode      (anode),
    .sevenSeg   (sevenSeg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Period counter since reset release: period t is the interval after the t-th clock edge
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Expected look of digit i in frame k for a given display state
  task automatic exp_digit(input rec_t r, input int k, input int i, output bit lit, output logic [7:0] seg);
    int          h;
    logic [3:0]  nib;
    bit          lzd;
    bit          bd;
    h = 0;
    for (int j = 0; j < N; j++) begin
      nib = r.data[4*j +: 4];
      if (nib != 4'h0) h = j;
    end
    lzd = r.lz && (i > h);
    bd  = (((k >> (BLINK - 1)) & 1) == 1) && r.mask[i];
    lit = !(lzd || bd);
    nib = r.data[4*i +: 4];
    seg = tbl[nib];
    if (r.dp[i]) seg[7] = 1'b0;
  endtask

  task automatic clear_acc();
    for (int i = 0; i < N; i++) begin
      lit_cnt[i]  = 0;
      seg_seen[i] = 8'h00;
      seg_bad[i]  = 1'b0;
    end
  endtask

  task automatic close_frame(input int k);
    bit         lit;
    logic [7:0] seg;
    while (q.size() > 0 && q[0].start <= k) cur = q.pop_front();
    for (int i = 0; i < N; i++) begin
      exp_digit(cur, k, i, lit, seg);
      if (lit) begin
        check($sformatf("frame%0d digit%0d lit_cycles", k, i), 32'(lit_cnt[i]), 32'(LIT));
        check($sformatf("frame%0d digit%0d sevenSeg", k, i),
              seg_bad[i] ? 32'h1FF : {24'h0, seg_seen[i]}, {24'h0, seg});
      end else begin
        check($sformatf("frame%0d digit%0d dark", k, i), 32'(lit_cnt[i]), 32'd0);
      end
    end
    clear_acc();
  endtask

  // Monitor: output in period t reflects DUT state of period t-1; frame k closes at t=FRAME*(k+1)
  always @(negedge clk) begin : monitor
    int         d;
    logic [3:0] oh;
    if (!rst) begin
      clear_acc();
      cur = '{0, 16'h0, 4'h0, 4'h0, 1'b0};
    end else if (!done && cyc > 0) begin
      check($sformatf("frame_tick t=%0d", cyc), {31'h0, frame_tick}, {31'h0, (cyc % FRAME) == FRAME - 1});
      if (anode == 4'hF) begin
        check($sformatf("dead_seg t=%0d", cyc), {24'h0, sevenSeg}, 32'hFF);
      end else begin
        d = -1;
        for (int i = 0; i < N; i++) begin
          oh = 4'b0001 << i;
          if (anode == ~oh) d = i;
        end
        if (d < 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL anode_onehot t=%0d: got %b expected one active-low bit", cyc, anode);
        end else begin
          if (lit_cnt[d] == 0) seg_seen[d] = sevenSeg;
          else if (seg_seen[d] !== sevenSeg) seg_bad[d] = 1'b1;
          lit_cnt[d]++;
        end
      end
      if ((cyc % FRAME) == 0) close_frame(cyc / FRAME - 1);
    end
  end

  // Offer one load; model decides in which period it is taken and the frame it first shows in
  task automatic do_load(input logic [15:0] ad, input logic [3:0] adp, input logic [3:0] amask, input logic alz);
    bit accepted;
    bit rdy;
    int t;
    int b;
    accepted = 1'b0;
    @(negedge clk);
    data_in    = ad;
    dp_in      = adp;
    blink_mask = amask;
    blank_lz   = alz;
    load_valid = 1'b1;
    for (int w = 0; w < 4 * FRAME && !accepted; w++) begin
      t   = cyc;
      rdy = (t > last_b);
      check($sformatf("load_ready t=%0d", t), {31'h0, load_ready}, {31'h0, rdy});
      if (rdy) begin
        b      = ((t + 1) / FRAME) * FRAME + FRAME - 1;
        last_b = b;
        q.push_back('{b / FRAME + 1, ad, adp, amask, alz});
        accepted = 1'b1;
        @(posedge clk);
        #1 load_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    if (!accepted) begin
      n_tests++;
      n_fail++;
      $display("FAIL load_timeout: got no acceptance expected acceptance within %0d cycles", 4 * FRAME);
      load_valid = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " anode"},      {28'h0, anode},      32'hF);
    check({tag, " sevenSeg"},   {24'h0, sevenSeg},   32'hFF);
    check({tag, " load_ready"}, {31'h0, load_ready}, 32'h1);
    check({tag, " frame_tick"}, {31'h0, frame_tick}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check_reset_outputs($sformatf("reset edge%0d", i));
    end
    @(negedge clk);
    rst = 1'b1;

    do_load(16'h1234, 4'h0, 4'h0, 1'b0);
    repeat (2 * FRAME) @(negedge clk);

    do_load(16'($urandom), 4'($urandom), 4'h0, 1'b0);
    do_load(16'($urandom), 4'($urandom), 4'h0, 1'b0);
    repeat (2 * FRAME) @(negedge clk);

    do_load(16'h0050, 4'h0, 4'h0, 1'b1);
    repeat (2 * FRAME) @(negedge clk);
    do_load(16'h0000, 4'hF, 4'h0, 1'b1);
    repeat (2 * FRAME) @(negedge clk);

    do_load(16'h8A7C, 4'h0, 4'b0001, 1'b0);
    repeat (4 * FRAME) @(negedge clk);

    for (int r = 0; r < 12; r++) begin
      do_load(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2 * FRAME)) @(negedge clk);
    end
    repeat (3 * FRAME) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);

    do_load(16'hABCD, 4'hF, 4'h0, 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    q.delete();
    last_b = -1;
    #1 check_reset_outputs("midrun reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3 * FRAME) @(negedge clk);

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
